// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   - fetch_state_e    : fetch FSM state encoding (RESET, REQ, HOLD, HALT)
//   - NOP_INSTR        : instruction presented while nothing has been fetched
//   - DEFAULT_RESET_PC : default program counter after reset
//   - addr_misaligned  : true when an address is not word aligned
//   - word_align       : clears the two byte-offset bits of an address
package fetch_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic addr_misaligned(input logic [31:0] addr);
        return (addr & 32'h0000_0003) != 32'h0000_0000;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_next.sv
// pc_next: purely combinational next-PC selection for the fetch stage.
// Ports:
//   pc              in  32  current program counter
//   pcsrc           in  1   take branch/jump
//   jalr            in  1   jump target comes from the ALU
//   pctarget        in  32  PC + imm
//   aluresult       in  32  rs1 + imm (JALR)
//   pc_plus4        out 32  pc + 4 (modulo 2^32)
//   next_pc         out 32  selected next program counter
//   next_misaligned out 1   selected target is not word aligned
// Build option FETCH_MISALIGN_CHECK_EN: when defined the raw target is passed
// through and its misalignment reported; otherwise the target is forced to a
// word boundary and next_misaligned is constant 0.
module pc_next
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        pcsrc,
    input  logic        jalr,
    input  logic [31:0] pctarget,
    input  logic [31:0] aluresult,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        next_misaligned
);

    logic [31:0] target_s;

    assign pc_plus4 = pc + 32'd4;

    // Select the raw target, then align or flag it depending on the build.
    always_comb begin
        target_s = pc_plus4;
        if (!pcsrc) begin
            target_s = pc_plus4;
        end else if (jalr) begin
            // JALR clears bit 0 of the computed address.
            target_s = aluresult & 32'hFFFF_FFFE;
        end else begin
            target_s = pctarget;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        next_pc         = target_s;
        next_misaligned = addr_misaligned(target_s);
`else
        next_pc         = word_align(target_s);
        next_misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, fetches one 32-bit word
// over a req/ack handshake, holds it for decode until execute accepts it, and
// then steps to the next PC chosen by pc_next.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     fetch request and word address (addr == PC)
//   imem_rdata/ack    returned instruction and completion strobe
//   Instr, PC         held instruction and its address
//   PCPlus4           PC + 4
//   instr_valid       Instr/PC valid
//   instr_ready       execute has completed Instr this cycle
//   PCSrc, Jalr       next-PC control from the controller
//   PCTarget          PC + imm
//   ALUResult         rs1 + imm for JALR
//   misaligned        sticky misaligned-target flag
// Build option FETCH_MISALIGN_CHECK_EN (handled in pc_next): a misaligned
// target halts fetch and sets misaligned; without it misaligned stays 0 and
// HALT is never entered.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic        Jalr,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    output logic        misaligned
);

    fetch_state_e state_r;
    logic [31:0]  pc_r;
    logic [31:0]  instr_r;
    logic         imem_req_r;
    logic         instr_valid_r;
    logic         misaligned_r;
    logic [31:0]  pc_plus4_s;
    logic [31:0]  next_pc_s;
    logic         next_misaligned_s;

    pc_next u_pc_next (
        .pc              (pc_r),
        .pcsrc           (PCSrc),
        .jalr            (Jalr),
        .pctarget        (PCTarget),
        .aluresult       (ALUResult),
        .pc_plus4        (pc_plus4_s),
        .next_pc         (next_pc_s),
        .next_misaligned (next_misaligned_s)
    );

    // Fetch FSM with its registered outputs and the PC/instruction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= RESET;
            pc_r          <= RESET_PC;
            instr_r       <= NOP_INSTR;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            misaligned_r  <= 1'b0;
        end else begin
            case (state_r)
                RESET: begin
                    state_r    <= REQ;
                    imem_req_r <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr_r       <= imem_rdata;
                        imem_req_r    <= 1'b0;
                        instr_valid_r <= 1'b1;
                        state_r       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid_r <= 1'b0;
                        if (next_misaligned_s) begin
                            // PC keeps the address of the offending jump.
                            misaligned_r <= 1'b1;
                            state_r      <= HALT;
                        end else begin
                            pc_r       <= next_pc_s;
                            imem_req_r <= 1'b1;
                            state_r    <= REQ;
                        end
                    end
                end
                HALT: begin
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
                default: begin
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                    state_r       <= RESET;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign Instr       = instr_r;
    assign PC          = pc_r;
    assign PCPlus4     = pc_plus4_s;
    assign instr_valid = instr_valid_r;
    assign misaligned  = misaligned_r;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V core: owns the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents each instruction (plus its PC) to decode/controller until execute accepts it. On acceptance it consumes the controller's PCSrc/Jalr outputs and the datapath's targets to select the next PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  core clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word-aligned fetch address; equals `PC` while `imem_req`=1.
- `imem_rdata`  in  32  instruction data, valid when `imem_ack`=1.
- `imem_ack`  in  1  memory completes the request this cycle.
- `Instr`  out  32  held instruction to decode (`op`=`Instr[6:0]`, `funct3`=`Instr[14:12]`, `funct7b5`=`Instr[30]`).
- `PC`  out  32  address of `Instr`.
- `PCPlus4`  out  32  `PC + 4`, for JAL/JALR writeback.
- `instr_valid`  out  1  `Instr`/`PC` are valid.
- `instr_ready`  in  1  execute has completed `Instr` this cycle.
- `PCSrc`  in  1  take branch/jump (from controller).
- `Jalr`  in  1  target comes from ALU (from controller).
- `PCTarget`  in  32  `PC + imm` from datapath.
- `ALUResult`  in  32  `rs1 + imm` for JALR.
- `misaligned`  out  1  sticky misaligned-target flag (only with `FETCH_MISALIGN_CHECK_EN`).

## Operation
- States: `RESET`, `REQ`, `HOLD`, `HALT`.
- `RESET`: entered asynchronously on `reset`=0. First edge with `reset`=1 -> `REQ`.
- `REQ`: `imem_req`=1, `imem_addr`=`PC`, both stable until ack. On edge with `imem_ack`=1: `Instr`<=`imem_rdata`, -> `HOLD`.
- `HOLD`: `instr_valid`=1, `Instr`/`PC` stable. On edge with `instr_ready`=1: `PC`<=next PC, -> `REQ`. Otherwise remain.
- Next PC (combinational, sampled only on accepting edge):
  - `PCSrc`=0: `PC + 4`.
  - `PCSrc`=1, `Jalr`=0: `PCTarget`.
  - `PCSrc`=1, `Jalr`=1: `{ALUResult[31:1], 1'b0}`.
- All adds modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- `imem_ack` outside `REQ` ignored; `instr_ready` outside `HOLD` ignored; `PCSrc`/`Jalr`/targets ignored except on the `HOLD`->`REQ` edge.
- `reset` asserted mid-request: `imem_req` drops immediately (async), pending ack discarded, `PC`<=`RESET_PC`.

## Timing
- Reset values: `PC`=`RESET_PC`, `Instr`=32'h0000_0013 (NOP), `instr_valid`=0, `imem_req`=0, `misaligned`=0; `imem_addr`=`PC`, `PCPlus4`=`PC+4` combinational.
- `imem_req` rises 1 cycle after reset release.
- Zero-wait memory (ack in first `REQ` cycle): `instr_valid` rises the following cycle; minimum throughput 1 instruction / 2 cycles.
- Each wait cycle of memory adds 1 cycle; each cycle `instr_ready`=0 in `HOLD` adds 1 cycle.
- Redirect latency: new target appears on `imem_addr` the cycle after the accepting edge.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: on the accepting edge, if the selected next PC has bits [1:0]≠0, `PC` is not updated, `misaligned`<=1, state -> `HALT`; `HALT` holds `imem_req`=0, `instr_valid`=0 until reset.
- Undefined: next PC bits [1:0] forced to 0; `misaligned` tied 0; `HALT` unreachable.

## Structure
- Shared package `fetch_pkg`: state encoding (`RESET`, `REQ`, `HOLD`, `HALT`), `NOP_INSTR`=32'h0000_0013, default `RESET_PC`.
- One sub-module `pc_next`: purely combinational next-PC mux (`PC`, `PCSrc`, `Jalr`, `PCTarget`, `ALUResult` -> next PC, misaligned bit). FSM and registers stay in `fetch_unit`.

## Test plan
- Reset release, memory acks in same cycle with 32'h00500093 -> `imem_addr`=0 on cycle 1, `instr_valid`=1 with `Instr`=32'h00500093, `PC`=0 on cycle 2.
- Sequential: accept with `PCSrc`=0 at `PC`=0x10 -> next `imem_addr`=0x14; 3 memory wait cycles -> `instr_valid` delayed exactly 3 cycles, `imem_addr` stable throughout.
- Branch: `PCSrc`=1, `Jalr`=0, `PCTarget`=0x40 -> next fetch 0x40; JALR: `PCSrc`=1, `Jalr`=1, `ALUResult`=0x105 -> next fetch 0x104.
- Backpressure: `instr_ready`=0 for 5 cycles -> `Instr`/`PC` unchanged, no `imem_req`; spurious `imem_ack` in `HOLD` ignored.
- Async reset asserted while `imem_req`=1 -> `imem_req`=0 same cycle, `PC`=`RESET_PC`; late ack after release not captured.
- With `FETCH_MISALIGN_CHECK_EN`: `PCTarget`=0x42 -> `misaligned`=1, `PC` stays, no further `imem_req`; without: fetch from 0x40, wrap test 0xFFFF_FFFC -> 0x0.
